axi_lite_master_arbiter: RTL and testbench

//  Shares one Avalon-to-AXI4-Lite master bridge between two Avalon-MM requesters (r0, r1).

---
 rtl/axi_lite_master_arbiter_if.sv | 56 +++++
 rtl/axi_lite_master_arbiter.sv | 117 +++++++++++
 tb/tb_axi_lite_master_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_master_arbiter_if.sv
// rtl/axi_lite_master_arbiter_if.sv - requester/bridge bundle for the two-master AXI4-Lite bridge arbiter
interface axi_lite_master_arbiter_if #(
  parameter int C_ADDR_WIDTH = 32,
  parameter int C_DATA_WIDTH = 32
);
  logic                      r0_read;
  logic                      r0_write;
  logic [C_ADDR_WIDTH-1:0]   r0_addr;
  logic [C_DATA_WIDTH/8-1:0] r0_be;
  logic [C_DATA_WIDTH-1:0]   r0_writedata;
  logic                      r0_waitreq;
  logic                      r0_readvalid;
  logic [C_DATA_WIDTH-1:0]   r0_readdata;
  logic                      r0_error;

  logic                      r1_read;
  logic                      r1_write;
  logic [C_ADDR_WIDTH-1:0]   r1_addr;
  logic [C_DATA_WIDTH/8-1:0] r1_be;
  logic [C_DATA_WIDTH-1:0]   r1_writedata;
  logic                      r1_waitreq;
  logic                      r1_readvalid;
  logic [C_DATA_WIDTH-1:0]   r1_readdata;
  logic                      r1_error;

  logic                      m_read;
  logic                      m_write;
  logic [C_ADDR_WIDTH-1:0]   m_addr;
  logic [C_DATA_WIDTH/8-1:0] m_be;
  logic [C_DATA_WIDTH-1:0]   m_writedata;
  logic                      m_waitreq;
  logic                      m_readvalid;
  logic [C_DATA_WIDTH-1:0]   m_readdata;

  logic                      grant_id;

  modport master (
    input  r0_read, r0_write, r0_addr, r0_be, r0_writedata,
    output r0_waitreq, r0_readvalid, r0_readdata, r0_error,
    input  r1_read, r1_write, r1_addr, r1_be, r1_writedata,
    output r1_waitreq, r1_readvalid, r1_readdata, r1_error,
    output m_read, m_write, m_addr, m_be, m_writedata,
    input  m_waitreq, m_readvalid, m_readdata,
    output grant_id
  );

  modport slave (
    output r0_read, r0_write, r0_addr, r0_be, r0_writedata,
    input  r0_waitreq, r0_readvalid, r0_readdata, r0_error,
    output r1_read, r1_write, r1_addr, r1_be, r1_writedata,
    input  r1_waitreq, r1_readvalid, r1_readdata, r1_error,
    input  m_read, m_write, m_addr, m_be, m_writedata,
    output m_waitreq, m_readvalid, m_readdata,
    input  grant_id
  );
endinterface

// File: rtl/axi_lite_master_arbiter.sv
// rtl/axi_lite_master_arbiter.sv - round-robin share of one Avalon-to-AXI4-Lite bridge between two requesters
module axi_lite_master_arbiter #(
  parameter int C_ADDR_WIDTH = 32,
  parameter int C_DATA_WIDTH = 32,
  parameter int C_TIMEOUT    = 255,
  parameter int C_TO_WIDTH   = 8
) (
  input  logic                        M_AXI_ACLK,
  input  logic                        M_AXI_ARESETN,
  axi_lite_master_arbiter_if.master   bus
);
  localparam int BE_W = C_DATA_WIDTH / 8;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_GAP} state_e;

  state_e                  state_q, state_d;
  logic                    grant_q, grant_d;
  logic                    m_read_q, m_read_d;
  logic                    m_write_q, m_write_d;
  logic [C_ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
  logic [BE_W-1:0]         m_be_q, m_be_d;
  logic [C_DATA_WIDTH-1:0] m_wd_q, m_wd_d;
  logic [C_TO_WIDTH-1:0]   cnt_q, cnt_d;

  logic req0, req1, sel, sel_wr, sel_rd;
  logic done, abort, fin0, fin1, rv0, rv1;

  assign req0   = bus.r0_read | bus.r0_write;
  assign req1   = bus.r1_read | bus.r1_write;
  // With both pending, the one not served last wins; grant_q resets to 1 so r0 goes first.
  assign sel    = (req0 & req1) ? ~grant_q : req1;
  assign sel_wr = sel ? bus.r1_write : bus.r0_write;
  assign sel_rd = sel ? bus.r1_read  : bus.r0_read;

  assign done  = (state_q == S_BUSY) &
                 ((m_write_q & ~bus.m_waitreq) | (m_read_q & bus.m_readvalid));
  assign abort = (state_q == S_BUSY) & ~done & (cnt_q == C_TO_WIDTH'(C_TIMEOUT - 1));

  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      state_q   <= S_IDLE;
      grant_q   <= 1'b1;
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
      m_addr_q  <= '0;
      m_be_q    <= '0;
      m_wd_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      m_read_q  <= m_read_d;
      m_write_q <= m_write_d;
      m_addr_q  <= m_addr_d;
      m_be_q    <= m_be_d;
      m_wd_q    <= m_wd_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    m_read_d  = m_read_q;
    m_write_d = m_write_q;
    m_addr_d  = m_addr_q;
    m_be_d    = m_be_q;
    m_wd_d    = m_wd_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req0 | req1) begin
          state_d   = S_BUSY;
          grant_d   = sel;
          m_write_d = sel_wr;
          m_read_d  = ~sel_wr & sel_rd;
          m_addr_d  = sel ? bus.r1_addr      : bus.r0_addr;
          m_be_d    = sel ? bus.r1_be        : bus.r0_be;
          m_wd_d    = sel ? bus.r1_writedata : bus.r0_writedata;
          cnt_d     = '0;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + C_TO_WIDTH'(1);
        if (done | abort) begin
          state_d   = S_GAP;
          m_read_d  = 1'b0;
          m_write_d = 1'b0;
        end
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A requester that dropped its request mid-transfer gets no completion pulse.
  assign fin0 = ~grant_q & (done | abort);
  assign fin1 =  grant_q & (done | abort);
  assign rv0  = fin0 & req0 & done & m_read_q;
  assign rv1  = fin1 & req1 & done & m_read_q;

  assign bus.r0_waitreq   = req0 & ~fin0;
  assign bus.r0_readvalid = rv0;
  assign bus.r0_readdata  = rv0 ? bus.m_readdata : '0;
  assign bus.r0_error     = fin0 & req0 & abort;
  assign bus.r1_waitreq   = req1 & ~fin1;
  assign bus.r1_readvalid = rv1;
  assign bus.r1_readdata  = rv1 ? bus.m_readdata : '0;
  assign bus.r1_error     = fin1 & req1 & abort;

  assign bus.m_read      = m_read_q;
  assign bus.m_write     = m_write_q;
  assign bus.m_addr      = m_addr_q;
  assign bus.m_be        = m_be_q;
  assign bus.m_writedata = m_wd_q;
  assign bus.grant_id    = grant_q;
endmodule

// File: tb/tb_axi_lite_master_arbiter.sv
// tb/tb_axi_lite_master_arbiter.sv - directed vectors and corner sequences for axi_lite_master_arbiter
module tb_axi_lite_master_arbiter;
  logic clk;
  logic resetn;
  int   n_checks;
  int   n_fail;

  axi_lite_master_arbiter_if #(.C_ADDR_WIDTH(32), .C_DATA_WIDTH(32)) bus ();

  axi_lite_master_arbiter #(
    .C_ADDR_WIDTH(32), .C_DATA_WIDTH(32), .C_TIMEOUT(8), .C_TO_WIDTH(4)
  ) dut (
    .M_AXI_ACLK(clk),
    .M_AXI_ARESETN(resetn),
    .bus(bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          n;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    int          lat;
    logic [31:0] rdata;
    int          exp_k;
    bit          exp_mw;
    bit          exp_mr;
    bit          exp_rv;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs [8];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic set_req(input bit n, input bit rd, input bit wr, input logic [31:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
    if (!n) begin
      bus.r0_read = rd; bus.r0_write = wr; bus.r0_addr = a; bus.r0_be = be; bus.r0_writedata = wd;
    end else begin
      bus.r1_read = rd; bus.r1_write = wr; bus.r1_addr = a; bus.r1_be = be; bus.r1_writedata = wd;
    end
  endtask

  function automatic logic own_wq(bit n);  return n ? bus.r1_waitreq   : bus.r0_waitreq;   endfunction
  function automatic logic own_rv(bit n);  return n ? bus.r1_readvalid : bus.r0_readvalid; endfunction
  function automatic logic own_err(bit n); return n ? bus.r1_error     : bus.r0_error;     endfunction
  function automatic logic [31:0] own_rd(bit n); return n ? bus.r1_readdata : bus.r0_readdata; endfunction

  task automatic run_vec(input int idx, input vec_t v);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    set_req(v.n, v.rd, v.wr, v.addr, v.be, v.wd);
    bus.m_waitreq = 1'b1; bus.m_readvalid = 1'b0; bus.m_readdata = v.rdata;
    #1 chk($sformatf("v%0d_idle_waitreq", idx), 32'(own_wq(v.n)), 32'd1);
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      bus.m_waitreq   = !(v.lat != 0 && k >= v.lat);
      bus.m_readvalid = (v.lat != 0 && k == v.lat) && !v.wr;
      #1;
      if (k == 1) begin
        chk($sformatf("v%0d_grant", idx), 32'(bus.grant_id), 32'(v.n));
        chk($sformatf("v%0d_m_addr", idx), bus.m_addr, v.addr);
        chk($sformatf("v%0d_m_be", idx), 32'(bus.m_be), 32'(v.be));
        chk($sformatf("v%0d_m_wd", idx), bus.m_writedata, v.wd);
      end
      chk($sformatf("v%0d_m_write", idx), 32'(bus.m_write), 32'(v.exp_mw));
      chk($sformatf("v%0d_m_read", idx), 32'(bus.m_read), 32'(v.exp_mr));
      if (!own_wq(v.n)) begin
        seen = 1'b1;
        chk($sformatf("v%0d_done_cycle", idx), 32'(k), 32'(v.exp_k));
        chk($sformatf("v%0d_readvalid", idx), 32'(own_rv(v.n)), 32'(v.exp_rv));
        chk($sformatf("v%0d_readdata", idx), own_rd(v.n), v.exp_rdata);
        chk($sformatf("v%0d_error", idx), 32'(own_err(v.n)), 32'(v.exp_err));
        chk($sformatf("v%0d_other_quiet", idx), 32'({own_rv(!v.n), own_err(!v.n)}), 32'd0);
      end
    end
    if (!seen) chk($sformatf("v%0d_no_completion", idx), 32'd0, 32'd1);
    @(negedge clk);
    set_req(v.n, 1'b0, 1'b0, '0, '0, '0);
    bus.m_waitreq = 1'b1; bus.m_readvalid = 1'b0;
    #1 chk($sformatf("v%0d_gap_idle_bus", idx), 32'({bus.m_write, bus.m_read}), 32'd0);
    @(negedge clk);
    #1 chk($sformatf("v%0d_idle_bus", idx), 32'({bus.m_write, bus.m_read}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   winner;
    vec_t v;
    n_checks = 0;
    n_fail   = 0;
    //           n  rd wr addr      be    wd            lat rdata          k  mw mr rv exp_rdata      err
    vecs[0] = '{0, 0, 1, 32'h10, 4'hF, 32'hA5A5A5A5, 3, 32'h0,        3, 1, 0, 0, 32'h0,        0};
    vecs[1] = '{1, 1, 0, 32'h20, 4'hF, 32'h0,        2, 32'h12345678, 2, 0, 1, 1, 32'h12345678, 0};
    vecs[2] = '{0, 1, 1, 32'h30, 4'h3, 32'h11112222, 1, 32'h0,        1, 1, 0, 0, 32'h0,        0};
    vecs[3] = '{0, 0, 1, 32'h40, 4'hC, 32'h33334444, 0, 32'h0,        8, 1, 0, 0, 32'h0,        1};
    vecs[4] = '{1, 1, 0, 32'h50, 4'hF, 32'h0,        0, 32'hBAD0BAD0, 8, 0, 1, 0, 32'h0,        1};
    vecs[5] = '{1, 1, 0, 32'h60, 4'hF, 32'h0,        7, 32'h0F0F0F0F, 7, 0, 1, 1, 32'h0F0F0F0F, 0};
    vecs[6] = '{0, 1, 0, 32'h70, 4'hF, 32'h0,        8, 32'hDEADBEEF, 8, 0, 1, 1, 32'hDEADBEEF, 0};
    vecs[7] = '{1, 0, 1, 32'h80, 4'h1, 32'h55AA55AA, 1, 32'h0,        1, 1, 0, 0, 32'h0,        0};

    resetn = 1'b0;
    set_req(1'b0, 1'b1, 1'b0, '0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, '0, '0, '0);
    bus.m_waitreq = 1'b1; bus.m_readvalid = 1'b0; bus.m_readdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_r0_waitreq", 32'(bus.r0_waitreq), 32'd1);
    chk("rst_m_rw", 32'({bus.m_write, bus.m_read}), 32'd0);
    chk("rst_grant", 32'(bus.grant_id), 32'd1);
    chk("rst_m_addr", bus.m_addr, 32'd0);
    chk("rst_m_be_wd", 32'(bus.m_be) | bus.m_writedata, 32'd0);
    chk("rst_pulses", 32'({bus.r0_readvalid, bus.r0_error, bus.r1_readvalid, bus.r1_error}), 32'd0);
    chk("rst_readdata", bus.r0_readdata | bus.r1_readdata, 32'd0);
    bus.r0_read = 1'b0;
    resetn = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Round robin with both requesters continuously pending.
    bus.m_waitreq = 1'b0;
    @(negedge clk);
    set_req(1'b0, 1'b0, 1'b1, 32'h100, 4'hF, 32'h1);
    set_req(1'b1, 1'b0, 1'b1, 32'h200, 4'hF, 32'h2);
    for (int r = 0; r < 4; r++) begin
      winner = -1;
      for (int c = 0; c < 10 && winner < 0; c++) begin
        #1;
        if (!bus.r0_waitreq) begin
          winner = 0;
          chk($sformatf("rr%0d_r1_waits", r), 32'(bus.r1_waitreq), 32'd1);
        end else if (!bus.r1_waitreq) begin
          winner = 1;
          chk($sformatf("rr%0d_r0_waits", r), 32'(bus.r0_waitreq), 32'd1);
        end
        if (winner < 0) @(negedge clk);
      end
      chk($sformatf("rr%0d_winner", r), 32'(winner), 32'(r % 2));
      @(negedge clk);
      if (winner == 1) bus.r1_write = 1'b0; else bus.r0_write = 1'b0;
      if (r == 3) begin bus.r0_write = 1'b0; bus.r1_write = 1'b0; end
      @(negedge clk);
      if (r < 3) begin
        if (winner == 1) bus.r1_write = 1'b1; else bus.r0_write = 1'b1;
      end
    end
    repeat (2) @(negedge clk);

    // Reset while BUSY abandons the transfer.
    bus.m_waitreq = 1'b1;
    set_req(1'b0, 1'b0, 1'b1, 32'h300, 4'hF, 32'h77);
    repeat (3) @(negedge clk);
    #1 chk("rstbusy_m_write_before", 32'(bus.m_write), 32'd1);
    resetn = 1'b0;
    bus.r0_write = 1'b0;
    @(negedge clk);
    #1;
    chk("rstbusy_m_rw", 32'({bus.m_write, bus.m_read}), 32'd0);
    chk("rstbusy_grant", 32'(bus.grant_id), 32'd1);
    chk("rstbusy_m_addr", bus.m_addr, 32'd0);
    resetn = 1'b1;
    v = '{0, 1, 0, 32'h310, 4'hF, 32'h0, 1, 32'h24681357, 1, 0, 1, 1, 32'h24681357, 0};
    run_vec(8, v);

    // A late bridge readvalid during GAP is not forwarded.
    @(negedge clk);
    bus.m_waitreq = 1'b0;
    set_req(1'b1, 1'b1, 1'b0, 32'h400, 4'hF, 32'h0);
    @(negedge clk);
    bus.m_readvalid = 1'b1; bus.m_readdata = 32'hCAFEF00D;
    #1 chk("gap_pre_readvalid", 32'(bus.r1_readvalid), 32'd1);
    @(negedge clk);
    #1;
    chk("gap_late_readvalid", 32'(bus.r1_readvalid), 32'd0);
    chk("gap_late_readdata", bus.r1_readdata, 32'd0);
    chk("gap_late_waitreq", 32'(bus.r1_waitreq), 32'd1);
    bus.r1_read = 1'b0; bus.m_readvalid = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
